// File: rtl/silife_census.sv
// silife_census: per-generation census stage for the silife grid.
//
// Scans the cell array one row per clock through a read-only row port,
// counting live cells. With SILIFE_CENSUS_SIGNATURE_EN defined it also folds
// every row into a 16-bit signature and flags a still life when two
// consecutive censuses produce the same signature.
//
// Configuration macro: SILIFE_CENSUS_SIGNATURE_EN
//   defined   : signature datapath, history, o_static and o_signature built
//   undefined : population only; o_static/o_signature tied 0, i_flush ignored
//
// Ports:
//   clk          in   clock
//   reset        in   synchronous, active-high reset
//   i_start      in   single-cycle census request, honoured only in IDLE
//   i_flush      in   invalidates signature history
//   i_cells      in   row contents, combinational from o_row_select
//   o_row_select out  row being sampled
//   o_busy       out  high while scanning
//   o_done       out  one-cycle pulse when results update
//   o_population out  live cells in the last completed census
//   o_static     out  last census signature equals the previous one
//   o_signature  out  signature of the last completed census
module silife_census #(
    parameter int WIDTH  = 32,
    parameter int HEIGHT = 32
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic                               i_start,
    input  logic                               i_flush,
    input  logic [WIDTH-1:0]                   i_cells,
    output logic [$clog2(HEIGHT)-1:0]          o_row_select,
    output logic                               o_busy,
    output logic                               o_done,
    output logic [$clog2(WIDTH*HEIGHT+1)-1:0]  o_population,
    output logic                               o_static,
    output logic [15:0]                        o_signature
);

    localparam int RW = $clog2(HEIGHT);
    localparam int PW = $clog2(WIDTH*HEIGHT+1);
    localparam logic [RW-1:0] LastRow = RW'(HEIGHT - 1);

    typedef enum logic [1:0] {
        StIdle,
        StScan,
        StDone
    } state_t;

    state_t          r_state;
    state_t          w_state_d;
    logic [RW-1:0]   r_row;
    logic [PW-1:0]   r_acc;
    logic [PW-1:0]   w_pop;
    logic [PW-1:0]   w_acc_next;
    logic            w_last_row;
    logic            w_finish;

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_d;
        end
    end

    always_comb begin
        w_state_d = r_state;
        case (r_state)
            StIdle:  if (i_start) w_state_d = StScan;
            StScan:  if (w_last_row) w_state_d = StDone;
            StDone:  w_state_d = StIdle;
            default: w_state_d = StIdle;
        endcase
    end

    assign w_last_row = (r_row == LastRow);
    // Results are registered on the edge that samples the last row so they
    // are already valid during the DONE cycle.
    assign w_finish   = (r_state == StScan) && w_last_row;

    assign o_busy       = (r_state == StScan);
    assign o_done       = (r_state == StDone);
    assign o_row_select = r_row;

    // ------------------------------------------------------------------
    // Population
    // ------------------------------------------------------------------
    always_comb begin
        w_pop = '0;
        for (int i = 0; i < WIDTH; i++) begin
            w_pop = w_pop + PW'(i_cells[i]);
        end
    end

    assign w_acc_next = r_acc + w_pop;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_row        <= '0;
            r_acc        <= '0;
            o_population <= '0;
        end else begin
            case (r_state)
                StIdle: begin
                    if (i_start) begin
                        r_acc <= '0;
                        r_row <= '0;
                    end
                end
                StScan: begin
                    r_acc <= w_acc_next;
                    if (w_last_row) begin
                        o_population <= w_acc_next;
                        r_row        <= '0;
                    end else begin
                        r_row <= r_row + RW'(1);
                    end
                end
                default: r_row <= '0;
            endcase
        end
    end

`ifdef SILIFE_CENSUS_SIGNATURE_EN
    // ------------------------------------------------------------------
    // Signature and still-life history
    // ------------------------------------------------------------------
    logic [15:0] r_sig;
    logic [15:0] w_fold;
    logic [15:0] w_sig_next;
    logic [15:0] r_prev_sig;
    logic        r_prev_valid;

    always_comb begin
        w_fold = '0;
        for (int s = 0; s < WIDTH / 16; s++) begin
            w_fold = w_fold ^ i_cells[s*16 +: 16];
        end
    end

    assign w_sig_next = {r_sig[14:0], r_sig[15]} ^ w_fold ^ 16'(r_row);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_sig        <= '0;
            r_prev_sig   <= '0;
            r_prev_valid <= 1'b0;
            o_static     <= 1'b0;
            o_signature  <= '0;
        end else begin
            if (r_state == StIdle && i_start) begin
                r_sig <= 16'hFFFF;
            end else if (r_state == StScan) begin
                r_sig <= w_sig_next;
            end

            if (w_finish) begin
                // A flush landing on the final row still forces o_static low,
                // but the finishing census becomes the new valid history.
                o_signature  <= w_sig_next;
                o_static     <= r_prev_valid && !i_flush && (w_sig_next == r_prev_sig);
                r_prev_sig   <= w_sig_next;
                r_prev_valid <= 1'b1;
            end else if (i_flush) begin
                o_static     <= 1'b0;
                r_prev_valid <= 1'b0;
            end
        end
    end
`else
    assign o_signature = '0;
    // i_flush has no history to act on; referenced only to keep the port used.
    assign o_static    = i_flush & 1'b0;
`endif

endmodule

// File: tb/tb_silife_census.sv
module tb_silife_census;

    localparam int WIDTH  = 32;
    localparam int HEIGHT = 32;
`ifdef SILIFE_CENSUS_SIGNATURE_EN
    localparam bit SigEn = 1'b1;
`else
    localparam bit SigEn = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        i_start = 1'b0;
    logic        i_flush = 1'b0;
    logic [31:0] i_cells;
    logic [4:0]  o_row_select;
    logic        o_busy;
    logic        o_done;
    logic [10:0] o_population;
    logic        o_static;
    logic [15:0] o_signature;

    logic [31:0] grid [HEIGHT];

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    assign i_cells = grid[o_row_select];

    silife_census #(.WIDTH(WIDTH), .HEIGHT(HEIGHT)) dut (
        .clk          (clk),
        .reset        (reset),
        .i_start      (i_start),
        .i_flush      (i_flush),
        .i_cells      (i_cells),
        .o_row_select (o_row_select),
        .o_busy       (o_busy),
        .o_done       (o_done),
        .o_population (o_population),
        .o_static     (o_static),
        .o_signature  (o_signature)
    );

    typedef struct {
        string name;
        int    kind;
        int    exp_pop;
    } vec_t;

    // ---------------- reference model ----------------
    function automatic int model_pop();
        int total = 0;
        for (int r = 0; r < HEIGHT; r++) total += $countones(grid[r]);
        return total;
    endfunction

    function automatic logic [15:0] model_sig();
        logic [15:0] s = 16'hFFFF;
        logic [31:0] row;
        logic [15:0] f;
        for (int r = 0; r < HEIGHT; r++) begin
            row = grid[r];
            f = row[15:0] ^ row[31:16];
            s = ((s << 1) | (s >> 15)) ^ f ^ 16'(r);
        end
        return SigEn ? s : 16'h0000;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    task automatic fill(input int kind);
        for (int r = 0; r < HEIGHT; r++) grid[r] = 32'h0;
        case (kind)
            1: for (int r = 0; r < HEIGHT; r++) grid[r] = 32'hFFFF_FFFF;
            2: begin  // glider
                grid[3] = 32'h2;
                grid[4] = 32'h4;
                grid[5] = 32'h7;
            end
            3: begin  // 2x2 block
                grid[10] = 32'h30;
                grid[11] = 32'h30;
            end
            4: begin
                grid[0]  = 32'h1;
                grid[31] = 32'h8000_0000;
            end
            5: for (int r = 0; r < HEIGHT; r++) grid[r] = r[0] ? 32'h5555_5555 : 32'hAAAA_AAAA;
            default: ;
        endcase
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Runs one census from IDLE. flush_at_row >= 0 raises i_flush while that
    // row is presented. Returns the results seen in the o_done cycle and
    // leaves the DUT one cycle later (back in IDLE).
    task automatic run_census(input bit flush_with_start, input int flush_at_row,
                              output int lat, output bit walk_ok,
                              output logic [10:0] pop, output logic [15:0] sig,
                              output logic stat, output logic done_after);
        int cnt;
        i_start = 1'b1;
        i_flush = flush_with_start;
        step();
        i_start = 1'b0;
        i_flush = 1'b0;
        cnt = 0;
        walk_ok = 1'b1;
        while (!o_done && cnt < 100) begin
            if (!o_busy || int'(o_row_select) != cnt) walk_ok = 1'b0;
            if (cnt == flush_at_row) i_flush = 1'b1;
            step();
            i_flush = 1'b0;
            cnt++;
        end
        lat  = cnt + 1;  // cycles from the request cycle to the o_done cycle
        pop  = o_population;
        sig  = o_signature;
        stat = o_static;
        if (o_busy || o_row_select != 5'd0) walk_ok = 1'b0;
        step();
        done_after = o_done;
    endtask

    initial begin
        vec_t        vecs [6];
        int          lat;
        bit          walk_ok;
        logic [10:0] pop;
        logic [15:0] sig;
        logic        stat;
        logic        done_after;
        int          done_t [$];
        int          guard;
        int          ndone;

        vecs[0] = '{"empty",   0, 0};
        vecs[1] = '{"full",    1, 1024};
        vecs[2] = '{"glider",  2, 5};
        vecs[3] = '{"block",   3, 4};
        vecs[4] = '{"corners", 4, 2};
        vecs[5] = '{"checker", 5, 512};

        fill(0);
        repeat (3) step();
        reset = 1'b0;
        check("reset_busy", o_busy, 0);
        check("reset_done", o_done, 0);
        check("reset_row", o_row_select, 0);
        check("reset_pop", o_population, 0);
        check("reset_static", o_static, 0);
        check("reset_sig", o_signature, 0);

        // Table-driven patterns
        for (int i = 0; i < 6; i++) begin
            fill(vecs[i].kind);
            run_census(1'b0, -1, lat, walk_ok, pop, sig, stat, done_after);
            check({vecs[i].name, "_pop"}, pop, vecs[i].exp_pop);
            check({vecs[i].name, "_latency"}, lat, HEIGHT + 1);
            check({vecs[i].name, "_rowwalk"}, walk_ok, 1);
            check({vecs[i].name, "_sig"}, sig, model_sig());
            check({vecs[i].name, "_done_pulse"}, done_after, 0);
            check({vecs[i].name, "_pop_hold"}, o_population, vecs[i].exp_pop);
        end

        // Still-life detection on the block
        fill(3);
        i_flush = 1'b1;
        step();
        i_flush = 1'b0;
        run_census(1'b0, -1, lat, walk_ok, pop, sig, stat, done_after);
        check("still_first_static", stat, 0);
        run_census(1'b0, -1, lat, walk_ok, pop, sig, stat, done_after);
        check("still_second_static", stat, SigEn);
        check("still_second_sig", sig, model_sig());
        check("still_second_pop", pop, 4);
        // Flush alone clears o_static next cycle, keeps results
        i_flush = 1'b1;
        step();
        i_flush = 1'b0;
        check("flush_static_cleared", o_static, 0);
        check("flush_pop_kept", o_population, 4);
        check("flush_sig_kept", o_signature, model_sig());
        run_census(1'b0, -1, lat, walk_ok, pop, sig, stat, done_after);
        check("after_flush_static", stat, 0);
        // Flush during scan: finishing census reports 0 but becomes history
        run_census(1'b0, 5, lat, walk_ok, pop, sig, stat, done_after);
        check("scan_flush_static", stat, 0);
        run_census(1'b0, -1, lat, walk_ok, pop, sig, stat, done_after);
        check("post_scan_flush_static", stat, SigEn);
        // Flush on the last row
        run_census(1'b0, HEIGHT - 1, lat, walk_ok, pop, sig, stat, done_after);
        check("lastrow_flush_static", stat, 0);
        // Start and flush together
        run_census(1'b1, -1, lat, walk_ok, pop, sig, stat, done_after);
        check("start_flush_static", stat, 0);

        // i_start held for 100 cycles
        done_t.delete();
        i_start = 1'b1;
        for (int c = 0; c < 100; c++) begin
            step();
            if (o_done) done_t.push_back(c);
        end
        i_start = 1'b0;
        ndone = done_t.size();
        check("hold_start_ndone", ndone, 2);
        if (ndone >= 2) begin
            check("hold_start_first", done_t[0], HEIGHT);
            check("hold_start_period", done_t[1] - done_t[0], HEIGHT + 2);
        end
        guard = 0;
        while (!o_done && guard < 100) begin
            step();
            guard++;
        end
        check("hold_start_drain", o_done, 1);
        step();

        // Reset mid-scan
        fill(1);
        i_start = 1'b1;
        step();
        i_start = 1'b0;
        guard = 0;
        while (o_row_select != 5'd10 && guard < 100) begin
            step();
            guard++;
        end
        check("midscan_reached_row10", o_row_select, 10);
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("midscan_busy", o_busy, 0);
        check("midscan_row", o_row_select, 0);
        check("midscan_pop", o_population, 0);
        check("midscan_done", o_done, 0);
        check("midscan_sig", o_signature, 0);
        ndone = 0;
        for (int c = 0; c < 40; c++) begin
            step();
            if (o_done) ndone++;
        end
        check("midscan_no_done", ndone, 0);
        run_census(1'b0, -1, lat, walk_ok, pop, sig, stat, done_after);
        check("fresh_pop", pop, 1024);
        check("fresh_latency", lat, HEIGHT + 1);
        check("fresh_static", stat, 0);
        check("fresh_sig", sig, model_sig());

        // Random grids against the model, each censused twice
        for (int k = 0; k < 6; k++) begin
            for (int r = 0; r < HEIGHT; r++) begin
                grid[r] = (k % 2 == 0) ? ($urandom() & $urandom()) : $urandom();
            end
            run_census(1'b0, -1, lat, walk_ok, pop, sig, stat, done_after);
            check("rand_pop", pop, model_pop());
            check("rand_sig", sig, model_sig());
            run_census(1'b0, -1, lat, walk_ok, pop, sig, stat, done_after);
            check("rand_repeat_static", stat, SigEn);
            check("rand_repeat_pop", pop, model_pop());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
